// File: rtl/axi_sram_if.sv
// axi_sram_if: single-beat AXI3 AR/R/AW/W/B bundle between the CPU-top bridge and the SRAM slave.
//   Parameter ID_W sets the width of arid/rid/awid/bid.
//   master modport: drives AR/AW/W payload+valid and rready/bready; samples the readies and R/B responses.
//   slave modport : the mirror image.
interface axi_sram_if #(
    parameter int ID_W = 4
);
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic            arvalid;
    logic            arready;
    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;
    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic            awvalid;
    logic            awready;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;
    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport master (
        output arid, araddr, arlen, arsize, arvalid, rready,
        output awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
        input  arready, rid, rdata, rresp, rlast, rvalid,
        input  awready, wready, bid, bresp, bvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arvalid, rready,
        input  awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
        output arready, rid, rdata, rresp, rlast, rvalid,
        output awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: single-beat AXI3 slave in front of a 2**MEM_AW x 32 word-addressed RAM.
//   aclk    : clock
//   aresetn : synchronous active-low reset (RAM contents kept, in-flight transfers dropped)
//   bus     : axi_sram_if.slave carrying AR/R/AW/W/B
// One outstanding read (RD_LAT cycles AR->rvalid) and one outstanding write. A read whose word
// matches a pending or presented write is held off until the B handshake completes.
// Define AXI_SLV_STALL_EN to add LFSR-driven random stalls on the readies and on rvalid.
module axi_sram_slave #(
    parameter int MEM_AW = 12,
    parameter int RD_LAT = 2,
    parameter int ID_W   = 4
) (
    input  logic        aclk,
    input  logic        aresetn,
    axi_sram_if.slave   bus
);
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;

    logic [31:0] mem [2**MEM_AW];

    logic stall;
`ifdef AXI_SLV_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;
    always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    always_ff @(posedge aclk) lfsr_q <= aresetn ? lfsr_d : 16'hACE1;
    assign stall = lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    logic [MEM_AW-1:0] ar_idx, aw_idx;
    assign ar_idx = bus.araddr[MEM_AW+1:2];
    assign aw_idx = bus.awaddr[MEM_AW+1:2];

    r_state_e          r_state_q, r_state_d;
    logic [3:0]        r_cnt_q, r_cnt_d;
    logic [MEM_AW-1:0] r_idx_q, r_idx_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;

    logic              aw_got_q, aw_got_d, w_got_q, w_got_d;
    logic [MEM_AW-1:0] aw_idx_q, aw_idx_d;
    logic [ID_W-1:0]   awid_q, awid_d;
    logic              aw_err_q, aw_err_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              bvalid_q, bvalid_d;
    logic [ID_W-1:0]   bid_q, bid_d;
    logic [1:0]        bresp_q, bresp_d;

    logic raw_hit, arready, awready, wready, ar_hs, aw_hs, w_hs, b_hs, wr_en;

    // A read must not overtake a write to the same word, whether latched or just being offered.
    assign raw_hit = (aw_got_q & (ar_idx == aw_idx_q)) | (bus.awvalid & (ar_idx == aw_idx));
    assign arready = (r_state_q == R_IDLE) & ~raw_hit & ~stall;
    assign awready = ~aw_got_q & ~bvalid_q & ~stall;
    assign wready  = ~w_got_q & ~bvalid_q & ~stall;
    assign ar_hs   = bus.arvalid & arready;
    assign aw_hs   = bus.awvalid & awready;
    assign w_hs    = bus.wvalid & wready;
    assign b_hs    = bvalid_q & bus.bready;
    assign wr_en   = aw_got_q & w_got_q & ~bvalid_q;

    always_comb begin
        r_state_d = r_state_q;
        r_cnt_d   = r_cnt_q;
        r_idx_d   = r_idx_q;
        rid_d     = rid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        rvalid_d  = rvalid_q;
        case (r_state_q)
            R_IDLE: if (ar_hs) begin
                r_state_d = R_WAIT;
                r_cnt_d   = 4'(RD_LAT - 1);
                r_idx_d   = ar_idx;
                rid_d     = bus.arid;
                rresp_d   = (bus.arlen != 8'd0) ? 2'b10 : 2'b00;
            end
            R_WAIT: if (r_cnt_q == 4'd0) begin
                r_state_d = R_RESP;
                rdata_d   = mem[r_idx_q];
                rvalid_d  = ~stall;
            end else begin
                r_cnt_d = r_cnt_q - 4'd1;
            end
            R_RESP: if (!rvalid_q) begin
                rvalid_d = 1'b1;
            end else if (bus.rready) begin
                r_state_d = R_IDLE;
                rvalid_d  = 1'b0;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        aw_got_d = b_hs ? 1'b0 : (aw_got_q | aw_hs);
        w_got_d  = b_hs ? 1'b0 : (w_got_q | w_hs);
        aw_idx_d = aw_hs ? aw_idx : aw_idx_q;
        awid_d   = aw_hs ? bus.awid : awid_q;
        aw_err_d = aw_hs ? (bus.awlen != 8'd0) : aw_err_q;
        wdata_d  = w_hs ? bus.wdata : wdata_q;
        wstrb_d  = w_hs ? bus.wstrb : wstrb_q;
        bvalid_d = b_hs ? 1'b0 : (bvalid_q | wr_en);
        bid_d    = wr_en ? awid_q : bid_q;
        bresp_d  = wr_en ? {aw_err_q, 1'b0} : bresp_q;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state_q <= R_IDLE;
            r_cnt_q   <= '0;
            r_idx_q   <= '0;
            rid_q     <= '0;
            rresp_q   <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            aw_idx_q  <= '0;
            awid_q    <= '0;
            aw_err_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_cnt_q   <= r_cnt_d;
            r_idx_q   <= r_idx_d;
            rid_q     <= rid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            aw_idx_q  <= aw_idx_d;
            awid_q    <= awid_d;
            aw_err_q  <= aw_err_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
        end
    end

    // RAM is never reset; a write pending at reset is dropped rather than committed.
    always_ff @(posedge aclk) begin
        if (aresetn && wr_en)
            for (int i = 0; i < 4; i++)
                if (wstrb_q[i]) mem[aw_idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
    end

    assign bus.arready = arready;
    assign bus.rid     = rid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign bus.rlast   = 1'b1;
    assign bus.rvalid  = rvalid_q;
    assign bus.awready = awready;
    assign bus.wready  = wready;
    assign bus.bid     = bid_q;
    assign bus.bresp   = bresp_q;
    assign bus.bvalid  = bvalid_q;

    logic unused_ok;
    assign unused_ok = ^{bus.arsize, bus.wlast, bus.araddr[31:MEM_AW+2], bus.araddr[1:0],
                         bus.awaddr[31:MEM_AW+2], bus.awaddr[1:0]};
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed scoreboard bench for axi_sram_slave (default build, RD_LAT=2).
module tb_axi_sram_slave;
    localparam int RD_LAT = 2;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    axi_sram_if #(.ID_W(4)) bus ();
    axi_sram_slave #(.MEM_AW(12), .RD_LAT(RD_LAT), .ID_W(4)) dut (
        .aclk(aclk), .aresetn(aresetn), .bus(bus)
    );

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
    } rsp_t;

    rsp_t rq[$];
    rsp_t bq[$];
    rsp_t re, be;
    int vectors = 0, miscompares = 0;
    int cyc = 0, ar_cyc = 0, aw_cyc = 0, w_cyc = 0;
    logic rv_prev = 1'b0, bv_prev = 1'b0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s", name);
    endtask

    // Monitor: latency on each valid rise, payload on each handshake.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (bus.rvalid && !rv_prev) chk("r_latency", 32'(cyc - ar_cyc), RD_LAT);
            if (bus.bvalid && !bv_prev) chk("b_latency", 32'(cyc - (aw_cyc > w_cyc ? aw_cyc : w_cyc)), 1);
            if (bus.rvalid && bus.rready) begin
                if (rq.size() == 0) fail_now("r_unexpected");
                else begin
                    re = rq.pop_front();
                    chk("rid", 32'(bus.rid), 32'(re.id));
                    chk("rdata", bus.rdata, re.data);
                    chk("rresp", 32'(bus.rresp), 32'(re.resp));
                    chk("rlast", 32'(bus.rlast), 1);
                end
            end
            if (bus.bvalid && bus.bready) begin
                if (bq.size() == 0) fail_now("b_unexpected");
                else begin
                    be = bq.pop_front();
                    chk("bid", 32'(bus.bid), 32'(be.id));
                    chk("bresp", 32'(bus.bresp), 32'(be.resp));
                end
            end
        end
        rv_prev = bus.rvalid;
        bv_prev = bus.bvalid;
    end

    task automatic send_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
        int n = 0;
        bus.araddr = a; bus.arid = id; bus.arlen = len; bus.arvalid = 1'b1;
        @(negedge aclk);
        while (!bus.arready && n < 200) begin @(negedge aclk); n++; end
        if (!bus.arready) fail_now("ar_timeout");
        @(posedge aclk); #1;
        ar_cyc = cyc;
        bus.arvalid = 1'b0;
    endtask

    task automatic send_aw(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
        int n = 0;
        bus.awaddr = a; bus.awid = id; bus.awlen = len; bus.awvalid = 1'b1;
        @(negedge aclk);
        while (!bus.awready && n < 200) begin @(negedge aclk); n++; end
        if (!bus.awready) fail_now("aw_timeout");
        @(posedge aclk); #1;
        aw_cyc = cyc;
        bus.awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
        @(negedge aclk);
        while (!bus.wready && n < 200) begin @(negedge aclk); n++; end
        if (!bus.wready) fail_now("w_timeout");
        @(posedge aclk); #1;
        w_cyc = cyc;
        bus.wvalid = 1'b0;
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic [3:0] id, input logic [7:0] len);
        bq.push_back('{id, 32'h0, (len != 0) ? 2'b10 : 2'b00});
        fork
            send_aw(a, id, len);
            send_w(d, s);
        join
    endtask

    task automatic read(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                        input logic [31:0] exp_d, input logic [1:0] exp_r);
        rq.push_back('{id, exp_d, exp_r});
        send_ar(a, id, len);
    endtask

    task automatic drain();
        int n = 0;
        while ((rq.size() != 0 || bq.size() != 0) && n < 200) begin @(negedge aclk); n++; end
        if (rq.size() != 0 || bq.size() != 0) begin
            fail_now("drain_timeout");
            rq.delete();
            bq.delete();
        end
        @(posedge aclk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = 3'b010; bus.arvalid = 1'b0;
        bus.rready = 1'b1;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b1; bus.wvalid = 1'b0;
        bus.bready = 1'b1;
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
        @(negedge aclk);
        chk("reset_rvalid", 32'(bus.rvalid), 0);
        chk("reset_bvalid", 32'(bus.bvalid), 0);
        chk("reset_rdata", bus.rdata, 0);
        chk("reset_rid", 32'(bus.rid), 0);
        chk("reset_bid", 32'(bus.bid), 0);
        chk("reset_rresp", 32'(bus.rresp), 0);
        chk("reset_bresp", 32'(bus.bresp), 0);
        chk("reset_arready", 32'(bus.arready), 1);
        chk("reset_awready", 32'(bus.awready), 1);
        chk("reset_wready", 32'(bus.wready), 1);
        @(posedge aclk); #1;

        write(32'h1C00_0010, 32'h1234_5678, 4'hF, 4'd1, 8'd0);
        drain();
        read(32'h1C00_0010, 4'd0, 8'd0, 32'h1234_5678, 2'b00);
        drain();

        write(32'h1C00_0010, 32'hAAAA_BBBB, 4'b0011, 4'd1, 8'd0);
        drain();
        read(32'h1C00_0010, 4'd0, 8'd0, 32'h1234_BBBB, 2'b00);
        drain();

        bq.push_back('{4'd1, 32'h0, 2'b00});
        rq.push_back('{4'd0, 32'hCAFE_F00D, 2'b00});
        fork
            begin
                send_aw(32'h1C00_0010, 4'd1, 8'd0);
                repeat (3) @(posedge aclk);
                #1;
                send_w(32'hCAFE_F00D, 4'hF);
            end
            begin
                @(posedge aclk); #1;
                send_ar(32'h1C00_0010, 4'd0, 8'd0);
            end
            begin
                int n = 0;
                bit done = 1'b0;
                @(posedge aclk); #1;
                while (!done && n < 60) begin
                    @(negedge aclk);
                    n++;
                    if (bus.arvalid) chk("raw_block_arready", 32'(bus.arready), 0);
                    done = bus.bvalid && bus.bready;
                end
                if (!done) fail_now("raw_b_timeout");
            end
        join
        drain();

        bus.rready = 1'b0;
        rq.push_back('{4'd1, 32'hCAFE_F00D, 2'b00});
        send_ar(32'h1C00_0010, 4'd1, 8'd0);
        begin
            int n = 0;
            @(negedge aclk);
            while (!bus.rvalid && n < 50) begin @(negedge aclk); n++; end
            if (!bus.rvalid) fail_now("rvalid_timeout");
            for (int k = 0; k < 4; k++) begin
                if (k != 0) @(negedge aclk);
                chk("hold_rvalid", 32'(bus.rvalid), 1);
                chk("hold_rdata", bus.rdata, 32'hCAFE_F00D);
                chk("hold_rid", 32'(bus.rid), 1);
                chk("hold_arready", 32'(bus.arready), 0);
            end
        end
        @(posedge aclk); #1;
        bus.rready = 1'b1;
        drain();

        write(32'h1C00_4014, 32'h1111_2222, 4'hF, 4'd0, 8'd0);
        drain();
        read(32'h0000_0014, 4'd3, 8'd0, 32'h1111_2222, 2'b00);
        drain();
        write(32'h0000_8014, 32'h3333_4444, 4'b1100, 4'd2, 8'd0);
        drain();
        read(32'h0000_0014, 4'd2, 8'd1, 32'h3333_2222, 2'b10);
        drain();
        write(32'h0000_0018, 32'hDEAD_BEEF, 4'hF, 4'd3, 8'd1);
        drain();
        read(32'h0000_0018, 4'd1, 8'd0, 32'hDEAD_BEEF, 2'b00);
        drain();

        rq.push_back('{4'd4, 32'hCAFE_F00D, 2'b00});
        bq.push_back('{4'd5, 32'h0, 2'b00});
        fork
            send_ar(32'h0000_0010, 4'd4, 8'd0);
            send_aw(32'h0000_001C, 4'd5, 8'd0);
            send_w(32'h0BAD_CAFE, 4'hF);
        join
        chk("ar_aw_same_cycle", 32'(ar_cyc), 32'(aw_cyc));
        drain();
        read(32'h0000_001C, 4'd6, 8'd0, 32'h0BAD_CAFE, 2'b00);
        drain();

        send_ar(32'h0000_0014, 4'd5, 8'd0);
        aresetn = 1'b0;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        repeat (3) begin
            @(negedge aclk);
            chk("rst_rwait_rvalid", 32'(bus.rvalid), 0);
            chk("rst_rwait_arready", 32'(bus.arready), 1);
        end
        @(posedge aclk); #1;
        read(32'h0000_001C, 4'd7, 8'd0, 32'h0BAD_CAFE, 2'b00);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
